// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the ID-stage immediate generator.
// Entry fields are sized for the widest datapath; narrower builds use the low bits.
package imm_gen_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_type_e           imm_type;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] target;
  } entry_t;

  // Immediate shifts use funct3 001 (sll) and 101 (srl/sra).
  function automatic logic is_shift(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> immediate and format code.
// Built at 64 bits internally and truncated, so one set of bit-placements serves both widths.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type
);

  logic [63:0] imm64;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_imm_bits;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  always_comb begin
    imm64    = '0;
    imm_type = IMM_NONE;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        imm64    = {{52{instruction[31]}}, instruction[31:20]};
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I;
        if (is_shift(funct3)) begin
          // funct7 bits never leak into the shift amount
          if (XLEN == 64) imm64 = {58'b0, instruction[25:20]};
          else            imm64 = {59'b0, instruction[24:20]};
        end else begin
          imm64 = {{52{instruction[31]}}, instruction[31:20]};
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          imm_type = IMM_I;
          if (is_shift(funct3)) imm64 = {59'b0, instruction[24:20]};
          else                  imm64 = {{52{instruction[31]}}, instruction[31:20]};
        end
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm64    = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm64    = {{51{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        imm64    = {{32{instruction[31]}}, instruction[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm64    = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          imm_type = IMM_Z;
          imm64    = {59'b0, instruction[19:15]};
        end else begin
          // CSR address, never sign-extended
          imm_type = IMM_I;
          imm64    = {52'b0, instruction[31:20]};
        end
      end
      default: begin
        imm_type = IMM_NONE;
        imm64    = '0;
      end
    endcase
  end

  assign imm             = imm64[XLEN-1:0];
  assign unused_imm_bits = ^imm64;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with PC+IMM adder and a 2-entry skid buffer.
// in_ready comes from a flop so there is no combinational path from out_ready.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_TARGET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic [XLEN-1:0] dec_target;
  entry_t          in_entry;

  entry_t main_q, skid_q;
  logic   main_vld_q, skid_vld_q, rdy_q;
  logic   main_vld_d, skid_vld_d;
  logic   ld_main_new, ld_main_skid, ld_skid;
  logic   in_fire, out_fire;
  logic   unused_entry_bits;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instruction (instruction),
    .imm         (dec_imm),
    .imm_type    (dec_type)
  );

  assign dec_target = EN_TARGET ? (pc_in + dec_imm) : '0;

  always_comb begin
    in_entry                    = '0;
    in_entry.imm[XLEN-1:0]      = dec_imm;
    in_entry.imm_type           = dec_type;
    in_entry.pc[XLEN-1:0]       = pc_in;
    in_entry.target[XLEN-1:0]   = dec_target;
  end

  assign in_fire  = in_valid & rdy_q;
  assign out_fire = main_vld_q & out_ready;

  always_comb begin
    main_vld_d   = main_vld_q;
    skid_vld_d   = skid_vld_q;
    ld_main_new  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!main_vld_q || out_fire) begin
      // main slot frees up: oldest waiting entry goes first
      if (skid_vld_q) begin
        ld_main_skid = 1'b1;
        main_vld_d   = 1'b1;
        skid_vld_d   = 1'b0;
      end else if (in_fire) begin
        ld_main_new = 1'b1;
        main_vld_d  = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      ld_skid    = 1'b1;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else if (flush) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
      if (ld_main_skid)     main_q <= skid_q;
      else if (ld_main_new) main_q <= in_entry;
      if (ld_skid)          skid_q <= in_entry;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_vld_q;
  assign imm       = main_q.imm[XLEN-1:0];
  assign imm_type  = main_q.imm_type;
  assign pc_out    = main_q.pc[XLEN-1:0];
  assign target    = main_q.target[XLEN-1:0];

  assign unused_entry_bits = ^main_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: directed vectors, backpressure, flush and reset.
// An XLEN=64 instance covers the wide sign-extension and shamt cases.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instruction, pc_in, imm, pc_out, target;
  logic [2:0]  imm_type;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [31:0] inst64;
  logic [63:0] pc64, imm64, pcout64, target64;
  logic [2:0]  type64;

  imm_gen_stage #(.XLEN(32), .EN_TARGET(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .imm_type(imm_type), .pc_out(pc_out), .target(target)
  );

  imm_gen_stage #(.XLEN(64), .EN_TARGET(1'b1)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .instruction(inst64), .pc_in(pc64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .imm(imm64), .imm_type(type64), .pc_out(pcout64), .target(target64)
  );

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  ty;
    logic [31:0] pc;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks the head entry every cycle it is presented, pops on transfer.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got pc=0x%0h required no output", pc_out);
      end else begin
        mon_e = exp_q[0];
        if ({imm, imm_type, pc_out, target} !== {mon_e.imm, mon_e.ty, mon_e.pc, mon_e.tgt}) begin
          n_bad++;
          $display("FAIL entry: got imm=0x%0h type=%0d pc=0x%0h target=0x%0h required imm=0x%0h type=%0d pc=0x%0h target=0x%0h",
                   imm, imm_type, pc_out, target, mon_e.imm, mon_e.ty, mon_e.pc, mon_e.tgt);
        end
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] eimm, input logic [2:0] ety, input logic [31:0] etgt);
    int waited = 0;
    exp_t e;
    instruction = ins;
    pc_in       = pc;
    in_valid    = 1'b1;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
    end else begin
      e.imm = eimm; e.ty = ety; e.pc = pc; e.tgt = etgt;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send64(input logic [31:0] ins, input logic [63:0] pc,
                        input logic [63:0] eimm, input logic [2:0] ety, input logic [63:0] etgt);
    inst64 = ins; pc64 = pc; in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    @(negedge clk);
    chk("w64_valid", {63'd0, out_valid64}, 64'd1);
    chk("w64_imm", imm64, eimm);
    chk("w64_type", {61'd0, type64}, {61'd0, ety});
    chk("w64_target", target64, etgt);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; pc_in = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; inst64 = '0; pc64 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_imm", {32'd0, imm}, 64'd0);
    chk("rst_type", {61'd0, imm_type}, 64'd0);
    chk("rst_pc_out", {32'd0, pc_out}, 64'd0);
    chk("rst_target", {32'd0, target}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Directed decode vectors, no backpressure
    send(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 3'd3, 32'h000000FC);   // beq -4
    @(negedge clk);
    chk("latency_1cycle", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    send(32'hFE000FE3, 32'h100, 32'hFFFFFFFE, 3'd3, 32'h000000FE);   // B with imm[4:1]=1111
    send(32'h001000EF, 32'h0,   32'h00000800, 3'd5, 32'h00000800);   // jal +2048
    send(32'h4050D093, 32'h200, 32'h00000005, 3'd1, 32'h00000205);   // srai 5
    send(32'h800002B7, 32'h300, 32'h80000000, 3'd4, 32'h80000300);   // lui
    send(32'hFFFFD073, 32'h400, 32'h0000001F, 3'd6, 32'h0000041F);   // csrrwi zimm=31
    send(32'h0000007F, 32'h500, 32'h00000000, 3'd0, 32'h00000500);   // undefined
    send(32'hFE20AC23, 32'h600, 32'hFFFFFFF8, 3'd2, 32'h000005F8);   // sw -8
    send(32'hFFF090F3, 32'h700, 32'h00000FFF, 3'd1, 32'h000016FF);   // csrrw 0xfff
    send(32'hFFF00093, 32'h010, 32'hFFFFFFFF, 3'd1, 32'h0000000F);   // addi -1
    send(32'h12345097, 32'hFFFFF000, 32'h12345000, 3'd4, 32'h12344000); // auipc, wraps
    send(32'h0010009B, 32'h020, 32'h00000000, 3'd0, 32'h00000020);   // addiw on RV32
    drain();

    // RV64 instance
    send64(32'h800002B7, 64'h1000, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80001000);
    send64(32'h4250D093, 64'h2000, 64'h0000000000000025, 3'd1, 64'h0000000000002025);
    send64(32'h4050D09B, 64'h3000, 64'h0000000000000005, 3'd1, 64'h0000000000003005);

    // Backpressure: five instructions, consumer stalled for a few cycles
    out_ready = 1'b0;
    send(32'h00100093, 32'h1000, 32'h00000001, 3'd1, 32'h00001001);
    send(32'h00200093, 32'h1004, 32'h00000002, 3'd1, 32'h00001006);
    chk("in_ready_full", {63'd0, in_ready}, 64'd0);
    fork
      begin
        send(32'h00300093, 32'h1008, 32'h00000003, 3'd1, 32'h0000100B);
        send(32'h00400093, 32'h100C, 32'h00000004, 3'd1, 32'h00001010);
        send(32'h00500093, 32'h1010, 32'h00000005, 3'd1, 32'h00001015);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with both entries full and an input offered
    out_ready = 1'b0;
    send(32'h00600093, 32'h2000, 32'h00000006, 3'd1, 32'h00002006);
    send(32'h00700093, 32'h2004, 32'h00000007, 3'd1, 32'h0000200B);
    instruction = 32'h00800093; pc_in = 32'h2008; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_full_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_full_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_full_dropped", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Flush with only main occupied, in_ready high: offered input must still be dropped
    out_ready = 1'b0;
    send(32'h00900093, 32'h3000, 32'h00000009, 3'd1, 32'h00003009);
    instruction = 32'h00A00093; pc_in = 32'h3004; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_main_dropped", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'h00B00093, 32'h4000, 32'h0000000B, 3'd1, 32'h0000400B);
    send(32'h00C00093, 32'h4004, 32'h0000000C, 3'd1, 32'h00004010);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_mid_imm", {32'd0, imm}, 64'd0);
    chk("rst_mid_type", {61'd0, imm_type}, 64'd0);
    chk("rst_mid_pc_out", {32'd0, pc_out}, 64'd0);
    chk("rst_mid_target", {32'd0, target}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    send(32'h0000006F, 32'h5000, 32'h00000000, 3'd5, 32'h00005000); // jal 0
    @(negedge clk);
    chk("rst_mid_latency", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
